// File: rtl/sabr_mul_share_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sabr_mul_share_arb
//  Description : Round-robin arbiter that shares one unsigned A_WIDTH x B_WIDTH
//                multiplier among NUM_REQ requesters. The product and its
//                owner ID are registered and returned over valid/ready.
//                Optional per-requester saturating grant counters are built
//                when the macro SABR_MUL_ARB_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module sabr_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int A_WIDTH = 83,
    parameter int B_WIDTH = 6,
    parameter int P_WIDTH = 89,
    parameter int ID_W    = 2
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [P_WIDTH-1:0]           rsp_p,
    output logic [NUM_REQ*16-1:0]        stat_grant_cnt
);

    // Output-register occupancy
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      w_ptr_nxt;
    logic [ID_W-1:0]      w_gnt_idx;
    logic [NUM_REQ-1:0]   w_gnt_oh;
    logic                 w_any;
    logic                 w_can_issue;
    logic                 w_xfer;
    logic [A_WIDTH-1:0]   w_a;
    logic [B_WIDTH-1:0]   w_b;
    logic [P_WIDTH-1:0]   w_p;
    int                   w_idx;

    // A new product may be loaded when the output register is free or draining.
    assign w_can_issue = (r_state == EMPTY) | rsp_ready;

    // Rotating priority search starting at the RR pointer; also muxes operands.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_gnt_oh  = '0;
        w_ptr_nxt = r_ptr;
        w_a       = '0;
        w_b       = '0;
        w_idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_any && req_valid[w_idx]) begin
                w_any            = 1'b1;
                w_gnt_idx        = ID_W'(w_idx);
                w_gnt_oh[w_idx]  = 1'b1;
                w_ptr_nxt        = ID_W'((w_idx + 1) % NUM_REQ);
                w_a              = req_a[w_idx*A_WIDTH +: A_WIDTH];
                w_b              = req_b[w_idx*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // Ready is suppressed while reset is asserted so nothing is accepted and lost.
    assign req_ready = (w_can_issue & w_any & ap_rst_n) ? w_gnt_oh : '0;
    assign w_xfer    = w_can_issue & w_any & ap_rst_n;

    // Both operands are zero-extended to the full product width with a clear
    // sign bit, so the signed multiply equals the unsigned product exactly.
    assign w_p = $signed({{B_WIDTH{1'b0}}, w_a}) * $signed({{A_WIDTH{1'b0}}, w_b});

    // Next-state logic for output-register occupancy
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = FULL;
        end else if (r_state == FULL && rsp_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    // State, pointer and result registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            rsp_id  <= '0;
            rsp_p   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_ptr  <= w_ptr_nxt;
                rsp_id <= w_gnt_idx;
                rsp_p  <= w_p;
            end
        end
    end

    assign rsp_valid = (r_state == FULL);

`ifdef SABR_MUL_ARB_STATS_EN
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
            logic [15:0] r_cnt;
            // Saturating count of accepted transfers from requester g
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    r_cnt <= '0;
                end else if (req_valid[g] && req_ready[g] && r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign stat_grant_cnt[g*16 +: 16] = r_cnt;
        end
    endgenerate
`else
    assign stat_grant_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sabr_mul_share_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sabr_mul_share_arb
//  Description : Scoreboard bench for sabr_mul_share_arb. Directed stimulus
//                pushes expected (id, product) pairs; a monitor pops them on
//                every accepted response. Stats checks follow
//                SABR_MUL_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sabr_mul_share_arb;
    localparam int NUM_REQ = 4;
    localparam int A_WIDTH = 83;
    localparam int B_WIDTH = 6;
    localparam int P_WIDTH = 89;
    localparam int ID_W    = 2;

    logic                        ap_clk = 1'b0;
    logic                        ap_rst_n;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*A_WIDTH-1:0]  req_a;
    logic [NUM_REQ*B_WIDTH-1:0]  req_b;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [ID_W-1:0]             rsp_id;
    logic [P_WIDTH-1:0]          rsp_p;
    logic [NUM_REQ*16-1:0]       stat_grant_cnt;

    sabr_mul_share_arb #(
        .NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH),
        .P_WIDTH(P_WIDTH), .ID_W(ID_W)
    ) u_dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_p          (rsp_p),
        .stat_grant_cnt (stat_grant_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [P_WIDTH-1:0] p;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   gcnt[NUM_REQ];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input int id, input logic [P_WIDTH-1:0] p);
        exp_t e;
        e.id = ID_W'(id);
        e.p  = p;
        q.push_back(e);
        gcnt[id]++;
    endtask

    task automatic set_op(input int i, input logic [A_WIDTH-1:0] a, input logic [B_WIDTH-1:0] b);
        req_a[i*A_WIDTH +: A_WIDTH] = a;
        req_b[i*B_WIDTH +: B_WIDTH] = b;
    endtask

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < NUM_REQ; i++) gcnt[i] = 0;
    endtask

    task automatic do_reset();
        ap_rst_n  = 1'b0;
        req_valid = '0;
        clr_cnt();
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
    endtask

    task automatic check_stats();
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SABR_MUL_ARB_STATS_EN
            chk($sformatf("stat_cnt%0d", i), 128'(stat_grant_cnt[i*16 +: 16]),
                128'((gcnt[i] > 65535) ? 65535 : gcnt[i]));
`else
            chk($sformatf("stat_zero%0d", i), 128'(stat_grant_cnt[i*16 +: 16]), 128'd0);
`endif
        end
    endtask

    // Response monitor: pops the scoreboard on every accepted product
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge ap_clk);
            if (ap_rst_n && rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got id=%0d p=%0h expected no response", rsp_id, rsp_p);
                end else begin
                    e = q.pop_front();
                    chk("rsp_id", 128'(rsp_id), 128'(e.id));
                    chk("rsp_p", 128'(rsp_p), 128'(e.p));
                end
            end
        end
    end

    // Directed stimulus
    initial begin : stim
        logic [P_WIDTH-1:0] big;
        ap_rst_n  = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        clr_cnt();

        // Reset then idle
        @(negedge ap_clk);
        chk("rst_valid", 128'(rsp_valid), 128'd0);
        chk("rst_id", 128'(rsp_id), 128'd0);
        chk("rst_p", 128'(rsp_p), 128'd0);
        chk("rst_ready", 128'(req_ready), 128'd0);
        req_valid = '0;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge ap_clk);
            chk("idle_valid", 128'(rsp_valid), 128'd0);
            chk("idle_ready", 128'(req_ready), 128'd0);
            chk("idle_p", 128'(rsp_p), 128'd0);
        end
        check_stats();

        // Single requester, maximal operands
        cyc();
        big = {{B_WIDTH{1'b0}}, {A_WIDTH{1'b1}}} * 89'd63;
        set_op(2, {A_WIDTH{1'b1}}, 6'd63);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge ap_clk);
        chk("t2_ready", 128'(req_ready), 128'(4'b0100));
        expect_rsp(2, big);
        cyc();
        req_valid = '0;
        @(negedge ap_clk);
        chk("t2_valid", 128'(rsp_valid), 128'd1);
        cyc();
        @(negedge ap_clk);
        chk("t2_drain", 128'(rsp_valid), 128'd0);

        // Round-robin fairness from a fresh pointer
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, A_WIDTH'(i + 1), 6'd2);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge ap_clk);
            chk($sformatf("rr_ready%0d", k), 128'(req_ready), 128'(4'b0001 << (k % 4)));
            expect_rsp(k % 4, P_WIDTH'(2 * ((k % 4) + 1)));
            cyc();
        end
        req_valid = '0;
        @(negedge ap_clk);
        cyc();

        // Backpressure: hold 1000*5, then back-to-back handoff to requester 3
        set_op(1, 83'd1000, 6'd5);
        set_op(3, 83'd7, 6'd3);
        req_valid = 4'b0010;
        @(negedge ap_clk);
        chk("bp_ready1", 128'(req_ready), 128'(4'b0010));
        expect_rsp(1, 89'd5000);
        cyc();
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge ap_clk);
            chk("bp_ready0", 128'(req_ready), 128'd0);
            chk("bp_valid", 128'(rsp_valid), 128'd1);
            chk("bp_id", 128'(rsp_id), 128'd1);
            chk("bp_p", 128'(rsp_p), 128'd5000);
            cyc();
        end
        rsp_ready = 1'b1;
        @(negedge ap_clk);
        chk("bp_ready3", 128'(req_ready), 128'(4'b1000));
        expect_rsp(3, 89'd21);
        cyc();
        req_valid = '0;
        @(negedge ap_clk);
        chk("bp_no_bubble", 128'(rsp_valid), 128'd1);
        cyc();
        @(negedge ap_clk);
        chk("bp_drain", 128'(rsp_valid), 128'd0);
        check_stats();

        // Asynchronous reset while holding a product
        cyc();
        set_op(2, 83'd9, 6'd9);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        @(negedge ap_clk);
        chk("ar_ready", 128'(req_ready), 128'(4'b0100));
        cyc();
        req_valid = '0;
        @(negedge ap_clk);
        chk("ar_held", 128'(rsp_valid), 128'd1);
        #1 ap_rst_n = 1'b0;
        clr_cnt();
        #1;
        chk("ar_valid_drop", 128'(rsp_valid), 128'd0);
        chk("ar_p_clear", 128'(rsp_p), 128'd0);
        #1 ap_rst_n = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        chk("ar_prio0", 128'(req_ready), 128'(4'b0001));
        expect_rsp(0, 89'd2);
        cyc();
        req_valid = '0;
        @(negedge ap_clk);
        cyc();
        check_stats();

`ifdef SABR_MUL_ARB_STATS_EN
        // Saturation of requester 0 counter
        set_op(0, 83'd1, 6'd1);
        req_valid = 4'b0001;
        for (int k = 0; k < 70000; k++) begin
            expect_rsp(0, 89'd1);
            cyc();
        end
        req_valid = '0;
        @(negedge ap_clk);
        cyc();
        chk("stat_sat0", 128'(stat_grant_cnt[15:0]), 128'h0000_FFFF);
        check_stats();
`endif

        repeat (2) cyc();
        chk("scoreboard_empty", 128'(q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
